// File: rtl/addsub_pipe.sv
// rtl/addsub_pipe.sv - two-stage add/subtract pipeline with 33-bit result and valid/ready handshake
module addsub_pipe #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_op,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_a,
   output logic [WIDTH-1:0] out_b,
   output logic [WIDTH:0]   out_diff,
   output logic [1:0]       out_op,
   output logic             out_ovf,
   output logic             out_zero,
   output logic             out_err,
   output logic [15:0]      op_count
);

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_RSV = 2'b11;

   logic             s1_valid_q, s1_valid_d;
   logic [1:0]       s1_op_q, s1_op_d;
   logic [WIDTH-1:0] s1_a_q, s1_a_d;
   logic [WIDTH-1:0] s1_b_q, s1_b_d;

   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_a_q, out_a_d;
   logic [WIDTH-1:0] out_b_q, out_b_d;
   logic [WIDTH:0]   out_diff_q, out_diff_d;
   logic [1:0]       out_op_q, out_op_d;
   logic             out_ovf_q, out_ovf_d;
   logic             out_zero_q, out_zero_d;
   logic             out_err_q, out_err_d;
   logic [15:0]      op_count_q, op_count_d;

   logic             s2_fire, s1_adv, in_ready_c, accept;
   logic [WIDTH:0]   ext_a, ext_b, result;

   always_comb begin
      s2_fire    = out_valid_q & out_ready;
      s1_adv     = s1_valid_q & (~out_valid_q | out_ready);
      // Depends only on registered state and out_ready, never on in_valid.
      in_ready_c = ~s1_valid_q | ~out_valid_q | out_ready;
      accept     = in_valid & in_ready_c;

      s1_valid_d = accept | (s1_valid_q & ~s1_adv);
      s1_op_d    = s1_op_q;
      s1_a_d     = s1_a_q;
      s1_b_d     = s1_b_q;
      if (accept) begin
         s1_op_d = in_op;
         s1_a_d  = in_a;
         s1_b_d  = in_b;
      end

      // Sign-extending to WIDTH+1 bits makes the top bit the exact sign.
      ext_a  = {s1_a_q[WIDTH-1], s1_a_q};
      ext_b  = {s1_b_q[WIDTH-1], s1_b_q};
      result = (s1_op_q == OP_ADD) ? (ext_a + ext_b) : (ext_a - ext_b);

      out_valid_d = s1_adv | (out_valid_q & ~s2_fire);
      out_a_d     = out_a_q;
      out_b_d     = out_b_q;
      out_diff_d  = out_diff_q;
      out_op_d    = out_op_q;
      out_ovf_d   = out_ovf_q;
      out_zero_d  = out_zero_q;
      out_err_d   = out_err_q;
      if (s1_adv) begin
         out_a_d    = s1_a_q;
         out_b_d    = s1_b_q;
         out_diff_d = result;
         out_op_d   = s1_op_q;
         out_ovf_d  = result[WIDTH] ^ result[WIDTH-1];
         out_zero_d = (result[WIDTH-1:0] == '0);
         out_err_d  = (s1_op_q == OP_RSV);
      end

      op_count_d = op_count_q;
      if (s2_fire && (op_count_q != 16'hFFFF)) begin
         op_count_d = op_count_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_valid_q  <= 1'b0;
         s1_op_q     <= '0;
         s1_a_q      <= '0;
         s1_b_q      <= '0;
         out_valid_q <= 1'b0;
         out_a_q     <= '0;
         out_b_q     <= '0;
         out_diff_q  <= '0;
         out_op_q    <= '0;
         out_ovf_q   <= 1'b0;
         out_zero_q  <= 1'b0;
         out_err_q   <= 1'b0;
         op_count_q  <= '0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_op_q     <= s1_op_d;
         s1_a_q      <= s1_a_d;
         s1_b_q      <= s1_b_d;
         out_valid_q <= out_valid_d;
         out_a_q     <= out_a_d;
         out_b_q     <= out_b_d;
         out_diff_q  <= out_diff_d;
         out_op_q    <= out_op_d;
         out_ovf_q   <= out_ovf_d;
         out_zero_q  <= out_zero_d;
         out_err_q   <= out_err_d;
         op_count_q  <= op_count_d;
      end
   end

   assign in_ready  = in_ready_c;
   assign out_valid = out_valid_q;
   assign out_a     = out_a_q;
   assign out_b     = out_b_q;
   assign out_diff  = out_diff_q;
   assign out_op    = out_op_q;
   assign out_ovf   = out_ovf_q;
   assign out_zero  = out_zero_q;
   assign out_err   = out_err_q;
   assign op_count  = op_count_q;

endmodule

// File: tb/tb_addsub_pipe.sv
// tb/tb_addsub_pipe.sv - scoreboard bench for addsub_pipe with randomized traffic and backpressure
module tb_addsub_pipe;

   localparam int W = 32;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [1:0]    in_op = 2'b00;
   logic [W-1:0]  in_a = '0;
   logic [W-1:0]  in_b = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [W-1:0]  out_a, out_b;
   logic [W:0]    out_diff;
   logic [1:0]    out_op;
   logic          out_ovf, out_zero, out_err;
   logic [15:0]   op_count;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [32:0] diff;
      logic [1:0]  op;
      logic        ovf;
      logic        zero;
      logic        err;
   } res_t;

   res_t exp_q[$];
   res_t held;
   bit   hold_v = 1'b0;
   int   exp_count = 0;
   int   mode = 1;
   int   n_vec = 0;
   int   n_fail = 0;

   addsub_pipe #(.WIDTH(W)) dut (
      .clk(clk), .reset_n(reset_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a), .in_b(in_b),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_a(out_a), .out_b(out_b), .out_diff(out_diff), .out_op(out_op),
      .out_ovf(out_ovf), .out_zero(out_zero), .out_err(out_err), .op_count(op_count)
   );

   always #5 clk = ~clk;

   // Reference: exact signed arithmetic in 64 bits, then classify.
   function automatic res_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, r;
      res_t   e;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      r  = (op == 2'b00) ? (sa + sb) : (sa - sb);
      e.a    = a;
      e.b    = b;
      e.op   = op;
      e.diff = r[32:0];
      e.ovf  = (r > 64'sd2147483647) || (r < -64'sd2147483648);
      e.zero = (r[31:0] == 32'd0);
      e.err  = (op == 2'b11);
      return e;
   endfunction

   function automatic res_t cur();
      res_t c;
      c = '{a: out_a, b: out_b, diff: out_diff, op: out_op, ovf: out_ovf, zero: out_zero, err: out_err};
      return c;
   endfunction

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic fail(input string name);
      n_vec++;
      n_fail++;
      $display("FAIL %s", name);
   endtask

   initial begin
      forever begin
         @(negedge clk);
         out_ready = (mode == 2) ? 1'($urandom % 2) : (mode == 1);
      end
   end

   // Monitor: results consumed at the next posedge when valid&ready at this sample.
   initial begin
      res_t e;
      forever begin
         @(negedge clk);
         #2;
         if (reset_n) begin
            check("op_count", op_count, exp_count);
            if (hold_v && out_valid) check("stable", cur(), held);
            if (out_valid && out_ready) begin
               if (exp_q.size() == 0) fail("unexpected_result");
               else begin
                  e = exp_q.pop_front();
                  check("result", cur(), e);
                  if (exp_count < 65535) exp_count++;
               end
               hold_v = 1'b0;
            end else if (out_valid) begin
               held   = cur();
               hold_v = 1'b1;
            end else begin
               hold_v = 1'b0;
            end
         end
      end
   end

   task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      int n;
      n = 0;
      @(negedge clk);
      in_valid = 1'b1;
      in_op = op;
      in_a = a;
      in_b = b;
      #1;
      while (!in_ready && n < 100) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (!in_ready) fail("accept_timeout");
      else exp_q.push_back(model(op, a, b));
   endtask

   task automatic idle();
      @(negedge clk);
      in_valid = 1'b0;
      in_op = 2'($urandom);
      in_a = $urandom;
      in_b = $urandom;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("drain_empty", exp_q.size(), 0);
   endtask

   task automatic reset_pulse(input int cnt_before);
      @(posedge clk);
      #3;
      reset_n = 1'b0;
      in_valid = 1'b0;
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_op_count", op_count, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_count_was", cnt_before, exp_count);
      exp_q.delete();
      exp_count = 0;
      hold_v = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
   endtask

   function automatic logic [31:0] pick();
      case ($urandom % 6)
         0: return 32'h0000_0000;
         1: return 32'h0000_0001;
         2: return 32'h7FFF_FFFF;
         3: return 32'h8000_0000;
         4: return 32'hFFFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      logic [1:0]  ops[8];
      logic [31:0] as[8], bs[8];
      int k, acc;

      #3;
      check("reset_in_ready", in_ready, 1);
      check("reset_out_valid", out_valid, 0);
      check("reset_op_count", op_count, 0);
      check("reset_out_diff", out_diff, 0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;

      // Directed corner cases and two-edge latency
      mode = 1;
      send(2'b00, 32'h7FFF_FFFF, 32'h0000_0001);
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      check("latency_not_yet", out_valid, 0);
      @(negedge clk);
      #1;
      check("latency_visible", out_valid, 1);
      check("add_ovf_diff", out_diff, 33'h0_8000_0000);
      send(2'b10, 32'h8000_0000, 32'h0000_0001);
      send(2'b01, 32'd5, 32'd5);
      send(2'b11, 32'd3, 32'd1);
      idle();
      drain();

      // Backpressure: only two requests fit
      reset_pulse(exp_count);
      for (int i = 0; i < 8; i++) begin
         ops[i] = 2'($urandom);
         as[i]  = $urandom;
         bs[i]  = $urandom;
      end
      mode = 0;
      k = 0;
      acc = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         in_valid = 1'b1;
         in_op = ops[k];
         in_a = as[k];
         in_b = bs[k];
         #1;
         if (in_ready) begin
            exp_q.push_back(model(ops[k], as[k], bs[k]));
            k++;
            acc++;
         end
      end
      check("bp_accepted", acc, 2);
      check("bp_in_ready", in_ready, 0);
      mode = 1;
      while (k < 8) begin
         send(ops[k], as[k], bs[k]);
         k++;
      end
      idle();
      drain();
      @(negedge clk);
      #3;
      check("bp_op_count", op_count, 8);

      // Reset with both stages full
      mode = 0;
      send(2'b00, $urandom, $urandom);
      send(2'b01, $urandom, $urandom);
      idle();
      @(negedge clk);
      #1;
      check("full_out_valid", out_valid, 1);
      check("full_in_ready", in_ready, 0);
      reset_pulse(8);

      // Random traffic with random backpressure
      mode = 2;
      for (int i = 0; i < 1000; i++) begin
         send(2'($urandom), pick(), pick());
         if ($urandom % 3 == 0) idle();
      end
      mode = 1;
      idle();
      drain();
      @(negedge clk);
      #3;
      check("final_op_count", op_count, exp_count);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
